// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the 16-bit processor datapath.
//
// Steps the datapath through fetch, decode and execute. The instruction word
// comes straight from the IR register in the datapath and is not latched here.
// The datapath only loads IR at the edge that ends Fetch, so IR is stable from
// Decode through to the end of execute.
//
// Ports
//   Clk         in   1   processor clock, rising-edge active
//   Reset       in   1   asynchronous, active-low; forces Init immediately
//   IR          in  16   [15:12] opcode, [11:8] A reg, [7:4] B reg,
//                        [11:4] data address, [3:0] dest/src reg
//   PC_clr      out  1   clear program counter
//   PC_up       out  1   increment program counter
//   IR_ld       out  1   load IR from instruction ROM
//   D_addr      out  8   data memory address
//   D_wr        out  1   data memory write enable
//   RF_s        out  1   register file write-data select (1 = memory, 0 = ALU)
//   RF_W_addr   out  4   register file write address
//   RF_W_en     out  1   register file write enable
//   RF_Ra_addr  out  4   register file port A read address
//   RF_Rb_addr  out  4   register file port B read address
//   ALU_s0      out  3   ALU function (000 pass A, 001 A+B, 010 A-B)
//   State       out  4   current state code
//   NextState   out  4   combinational next-state code
module control_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  State,
  output logic [3:0]  NextState
);

  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoop   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_e;

  localparam logic [3:0] OpLoad  = 4'b0001;
  localparam logic [3:0] OpStore = 4'b0010;
  localparam logic [3:0] OpAdd   = 4'b0011;
  localparam logic [3:0] OpSub   = 4'b0100;
  localparam logic [3:0] OpHalt  = 4'b0101;

  localparam logic [2:0] AluPass = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;

  state_e     r_state;
  state_e     w_next;
  logic [3:0] w_opcode;
  logic [7:0] w_daddr;
  logic [3:0] w_ra_fld;
  logic [3:0] w_rb_fld;
  logic [3:0] w_rd_fld;

  assign w_opcode = IR[15:12];
  assign w_daddr  = IR[11:4];
  assign w_ra_fld = IR[11:8];
  assign w_rb_fld = IR[7:4];
  assign w_rd_fld = IR[3:0];

  // State register; the asynchronous clear also kills any write enable in
  // the same cycle because all outputs decode from r_state alone.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= StInit;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = StInit;
    case (r_state)
      StInit:   w_next = StFetch;
      StFetch:  w_next = StDecode;
      StDecode: begin
        case (w_opcode)
          OpLoad:  w_next = StLoadA;
          OpStore: w_next = StStore;
          OpAdd:   w_next = StAdd;
          OpSub:   w_next = StSub;
          OpHalt:  w_next = StHalt;
          default: w_next = StNoop;  // unused opcodes behave as NOOP
        endcase
      end
      StLoadA:  w_next = StLoadB;
      StLoadB,
      StStore,
      StAdd,
      StSub,
      StNoop:   w_next = StFetch;
      StHalt:   w_next = StHalt;
      default:  w_next = StInit;     // codes 10..15 recover to Init
    endcase
  end

  // Moore outputs: function of r_state and IR only
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = 8'h00;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = 4'h0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALU_s0     = AluPass;
    case (r_state)
      StInit: PC_clr = 1'b1;
      StFetch: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      // Present the address during Decode so the synchronous RAM read has
      // already started by the time LoadA is reached.
      StDecode: D_addr = w_daddr;
      StLoadA: begin
        D_addr = w_daddr;
        RF_s   = 1'b1;
      end
      StLoadB: begin
        D_addr    = w_daddr;
        RF_s      = 1'b1;
        RF_W_addr = w_rd_fld;
        RF_W_en   = 1'b1;
      end
      StStore: begin
        D_addr     = w_daddr;
        RF_Ra_addr = w_rd_fld;
        D_wr       = 1'b1;
      end
      StAdd: begin
        RF_Ra_addr = w_ra_fld;
        RF_Rb_addr = w_rb_fld;
        RF_W_addr  = w_rd_fld;
        RF_W_en    = 1'b1;
        ALU_s0     = AluAdd;
      end
      StSub: begin
        RF_Ra_addr = w_ra_fld;
        RF_Rb_addr = w_rb_fld;
        RF_W_addr  = w_rd_fld;
        RF_W_en    = 1'b1;
        ALU_s0     = AluSub;
      end
      default: ;                     // Noop, Halt, unreachable: all zero
    endcase
  end

  assign State     = r_state;
  assign NextState = w_next;

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit. A program of instructions is
// expanded into a per-cycle list of (reset, IR, state) using the instruction
// cycle counts; expected outputs are pushed when each cycle is driven and a
// separate monitor pops and compares them on the falling edge.
module tb_control_unit;

  logic        Clk;
  logic        Reset;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, State, NextState;
  logic [2:0]  ALU_s0;

  control_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .State      (State),
    .NextState  (NextState)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // {State, NextState, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
  //  RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0}
  typedef logic [36:0] vec_t;

  typedef struct {
    logic        rst_n;
    logic [15:0] ir;
    int          st;
    int          nx;
  } cyc_t;

  cyc_t        cyc_q[$];
  vec_t        exp_q[$];
  logic [15:0] cur_ir;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic vec_t actual_vec();
    return {State, NextState, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s,
            RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};
  endfunction

  // Output table for each state, taken from the instruction semantics.
  function automatic vec_t model(input int st, input int nx, input logic [15:0] ir);
    logic       clr = 0, up = 0, ld = 0, wr = 0, s = 0, wen = 0;
    logic [7:0] da = 0;
    logic [3:0] wa = 0, ra = 0, rb = 0;
    logic [2:0] alu = 0;
    case (st)
      0: clr = 1;
      1: begin ld = 1; up = 1; end
      2: da = ir[11:4];
      4: begin da = ir[11:4]; s = 1; end
      5: begin da = ir[11:4]; s = 1; wa = ir[3:0]; wen = 1; end
      6: begin da = ir[11:4]; ra = ir[3:0]; wr = 1; end
      7, 8: begin
        ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; wen = 1;
        alu = (st == 7) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
    return {st[3:0], nx[3:0], clr, up, ld, da, wr, s, wa, wen, ra, rb, alu};
  endfunction

  task automatic check(input string name, input vec_t exp);
    vec_t act = actual_vec();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h (State=%0d) expected %h (State=%0d)",
               name, $time, act, act[36:33], exp, exp[36:33]);
    end
  endtask

  task automatic add_cyc(input logic r, input logic [15:0] ir, input int st);
    cyc_t c;
    c.rst_n = r; c.ir = ir; c.st = st; c.nx = -1;
    cyc_q.push_back(c);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) add_cyc(1'b0, cur_ir, 0);
    add_cyc(1'b1, cur_ir, 0);  // first released cycle is still Init
  endtask

  // Fetch (old IR still visible), Decode (new IR), then execute cycles.
  task automatic add_instr(input logic [15:0] ir);
    add_cyc(1'b1, cur_ir, 1);
    cur_ir = ir;
    add_cyc(1'b1, ir, 2);
    case (ir[15:12])
      4'd1: begin add_cyc(1'b1, ir, 4); add_cyc(1'b1, ir, 5); end
      4'd2: add_cyc(1'b1, ir, 6);
      4'd3: add_cyc(1'b1, ir, 7);
      4'd4: add_cyc(1'b1, ir, 8);
      4'd5: for (int i = 0; i < 20; i++) add_cyc(1'b1, ir, 9);
      default: add_cyc(1'b1, ir, 3);
    endcase
  endtask

  // Monitor: one expected vector per driven cycle, sampled mid-cycle.
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      check("cycle", e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rnd;
    Reset  = 1'b1;
    IR     = 16'h0000;
    cur_ir = 16'h0000;
    #1 Reset = 1'b0;
    #1 check("async_reset_no_clock", model(0, 1, IR));

    // Directed program
    add_reset(3);
    add_instr(16'h3124);
    add_instr(16'h11A7);
    add_instr(16'h2203);
    add_instr(16'hF123);
    add_instr(16'h4ABC);
    add_instr(16'h0000);
    add_instr(16'h5000);
    add_reset(2);
    // Random blocks, each ending in HALT and a reset
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 30; k++) begin
        rnd = 16'($urandom());
        while (rnd[15:12] == 4'd5) rnd = 16'($urandom());
        add_instr(rnd);
      end
      add_instr({4'd5, 12'($urandom())});
      add_reset(1 + int'($urandom_range(0, 2)));
    end

    // Expected next state: Halt holds, reset forces Init->Fetch, else follow.
    foreach (cyc_q[i]) begin
      if (!cyc_q[i].rst_n)              cyc_q[i].nx = 1;
      else if (cyc_q[i].st == 9)        cyc_q[i].nx = 9;
      else if (i + 1 < cyc_q.size())    cyc_q[i].nx = cyc_q[i + 1].st;
      else                              cyc_q[i].nx = 1;
    end

    foreach (cyc_q[i]) begin
      @(posedge Clk);
      #1;
      Reset = cyc_q[i].rst_n;
      IR    = cyc_q[i].ir;
      exp_q.push_back(model(cyc_q[i].st, cyc_q[i].nx, cyc_q[i].ir));
    end

    // Reset pulsed during Store: the write must vanish within the cycle.
    @(posedge Clk); #1;
    exp_q.push_back(model(1, 2, IR));
    @(posedge Clk); #1;
    IR = 16'h2203;
    exp_q.push_back(model(2, 6, IR));
    @(posedge Clk); #1;
    exp_q.push_back(model(6, 1, IR));
    @(negedge Clk); #1;
    Reset = 1'b0;
    #1 check("midstore_reset_async", model(0, 1, IR));
    @(posedge Clk); #1;
    check("midstore_reset_hold", model(0, 1, IR));
    Reset = 1'b1;
    @(posedge Clk); #1;
    check("fetch_after_reset", model(1, 2, IR));

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge Clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore state machine that sequences the 16-bit processor datapath through fetch, decode and execute. It sits beside the datapath inside the processor, takes the registered instruction word from the IR, and drives the PC, instruction register, data memory, register file and ALU control lines. It also exports current and next state codes for the hex display selector.

## Interface
- No parameters; all widths are fixed by the 16-bit ISA.
- Clk  input  1  processor clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low; 0 forces state Init immediately.
- IR  input  16  current instruction from the IR. Fields: [15:12] opcode, [11:8] A register, [7:4] B register, [11:4] data address, [3:0] destination/source register.
- PC_clr  output  1  clears the PC.
- PC_up  output  1  increments the PC.
- IR_ld  output  1  loads the IR from instruction ROM at the current PC.
- D_addr  output  8  data memory address.
- D_wr  output  1  data memory write enable.
- RF_s  output  1  register file write-data select: 1 = data memory, 0 = ALU.
- RF_W_addr  output  4  register file write address.
- RF_W_en  output  1  register file write enable.
- RF_Ra_addr  output  4  register file port A read address.
- RF_Rb_addr  output  4  register file port B read address.
- ALU_s0  output  3  ALU function: 000 = pass A, 001 = A+B, 010 = A−B.
- State  output  4  current state code.
- NextState  output  4  combinational next state code.

## Operation
- State codes: Init=0, Fetch=1, Decode=2, Noop=3, LoadA=4, LoadB=5, Store=6, Add=7, Sub=8, Halt=9. Codes 10–15 are unreachable; if one is ever entered, NextState is Init.
- Opcodes: 0000 NOOP; 0001 LOAD (R[IR[3:0]] ← D[IR[11:4]]); 0010 STORE (D[IR[11:4]] ← R[IR[3:0]]); 0011 ADD (R[IR[3:0]] ← R[IR[11:8]] + R[IR[7:4]]); 0100 SUB (same operands, A−B); 0101 HALT. Opcodes 0110–1111 decode as NOOP.
- Transitions:
  - Init→Fetch, then Fetch→Decode.
  - Decode→Noop, LoadA, Store, Add, Sub or Halt by opcode.
  - LoadA→LoadB.
  - LoadB, Store, Add, Sub and Noop each go →Fetch.
  - Halt→Halt until Reset.
- Outputs are a pure function of State and IR. Any output not listed for a state is 0, including all address buses.
  - Init: PC_clr=1.
  - Fetch: IR_ld=1, PC_up=1.
  - Decode: D_addr=IR[11:4], so the synchronous RAM read starts early.
  - LoadA: D_addr=IR[11:4], RF_s=1.
  - LoadB: D_addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=1.
  - Store: D_addr=IR[11:4], RF_Ra_addr=IR[3:0], D_wr=1.
  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, ALU_s0=001, RF_s=0.
  - Sub: as Add, with ALU_s0=010.
  - Noop and Halt: all zero.
- IR changes only at the Fetch edge. The controller does not latch IR; it relies on IR being stable from Decode through execute.

## Timing
- Reset low: State=0 and outputs equal the Init outputs (PC_clr=1, everything else 0) within the same cycle, with no clock needed. NextState=1.
- First rising edge after Reset is released: State=Fetch.
- Cycles per instruction, counted from Fetch: NOOP, STORE, ADD and SUB take 3; LOAD takes 4; HALT takes 2 and then stays in Halt.
- Exactly one D_wr pulse per STORE and one RF_W_en pulse per LOAD, ADD or SUB. Each pulse is one Clk cycle, and the write happens at the edge ending that cycle.
- PC_up is high for exactly one cycle per instruction. The PC never advances outside Fetch.
- Reset asserted mid-instruction (for example in Store or LoadB) drops D_wr and RF_W_en combinationally. No partial write may occur at the next edge.
- In Halt, Clk edges have no effect: all outputs stay 0 and State stays 9.

## Test plan
- Reset held low for 3 cycles → State=0, NextState=1, PC_clr=1, all other outputs 0; after release, State sequence 1,2.
- IR=16'h3124 (ADD) in Decode → Add state for one cycle with Ra=1, Rb=2, W_addr=4, W_en=1, ALU_s0=001, RF_s=0; then Fetch.
- IR=16'h11A7 (LOAD) → states 2,4,5,1. D_addr=8'h1A in states 2, 4 and 5; RF_s=1 in 4 and 5; RF_W_en=1 and W_addr=7 only in state 5.
- IR=16'h2203 (STORE) → Store state with D_addr=8'h20, Ra=3, D_wr=1 for exactly one cycle.
- IR=16'h5000 (HALT) → State=9 for 20 subsequent cycles with all outputs 0; IR=16'hF123 → Noop then Fetch with no write enables.
- Reset pulsed low mid-Store → D_wr falls in the same cycle and State=0; after release, 1 cycle to Fetch.
